// File: rtl/mvu_outwr.sv
// Output write-back stage: per-MVU FIFOs with base/stride address generation,
// drained round-robin onto a single shared data-memory write bus.
module mvu_outwr #(
    parameter int NMVU    = 8,
    parameter int N       = 64,
    parameter int BDBANKA = 15,
    parameter int FDEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NMVU-1:0]           start,
    input  logic [NMVU*BDBANKA-1:0]   obaseaddr,
    input  logic [NMVU*BDBANKA-1:0]   ostride,
    input  logic [NMVU*BDBANKA-1:0]   ocount,
    input  logic [NMVU-1:0]           q_valid,
    input  logic [NMVU*N-1:0]         q_word,
    output logic [NMVU-1:0]           q_ready,
    output logic [NMVU-1:0]           wrc_en,
    input  logic [NMVU-1:0]           wrc_grnt,
    output logic [BDBANKA-1:0]        wrc_addr,
    output logic [N-1:0]              wrc_word,
    output logic [NMVU-1:0]           busy,
    output logic [NMVU-1:0]           done
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(NMVU);

    logic [NMVU-1:0]    pop;
    logic [NMVU-1:0]    nonempty_eff;
    logic [N-1:0]       head_eff [NMVU];
    logic [BDBANKA-1:0] addr_eff [NMVU];
    logic               bus_free;

    // A start on the channel holding the bus aborts the request without a pop.
    assign pop      = wrc_en & wrc_grnt & ~start;
    assign bus_free = (wrc_en == '0) || (pop != '0) || ((wrc_en & start) != '0);

    for (genvar gi = 0; gi < NMVU; gi++) begin : g_chan
        logic [N-1:0]       mem [FDEPTH];
        logic [PW-1:0]      wptr_reg;
        logic [PW-1:0]      rptr_reg;
        logic [CW-1:0]      cnt_reg;
        logic [BDBANKA-1:0] acc_reg;
        logic [BDBANKA-1:0] wrl_reg;
        logic [BDBANKA-1:0] addr_reg;
        logic [BDBANKA-1:0] stride_reg;
        logic               busy_reg;
        logic               done_reg;
        logic               full;
        logic               push;
        logic [BDBANKA-1:0] cnt_in;

        assign full         = (cnt_reg == CW'(FDEPTH));
        assign q_ready[gi]  = busy_reg & ~full & (acc_reg != '0);
        assign push         = q_valid[gi] & q_ready[gi] & ~start[gi];
        assign cnt_in       = ocount[gi*BDBANKA +: BDBANKA];
        assign busy[gi]     = busy_reg;
        assign done[gi]     = done_reg;

        // Occupancy/head/address as they will look after this edge's pop, so the
        // arbiter can issue the next request back-to-back.
        assign nonempty_eff[gi] = ~start[gi] &
                                  (pop[gi] ? (cnt_reg > CW'(1)) : (cnt_reg != '0));
        assign head_eff[gi]     = mem[rptr_reg + PW'(pop[gi])];
        assign addr_eff[gi]     = pop[gi] ? (addr_reg + stride_reg) : addr_reg;

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr_reg] <= q_word[gi*N +: N];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr_reg   <= '0;
                rptr_reg   <= '0;
                cnt_reg    <= '0;
                acc_reg    <= '0;
                wrl_reg    <= '0;
                addr_reg   <= '0;
                stride_reg <= '0;
                busy_reg   <= 1'b0;
                done_reg   <= 1'b0;
            end else begin
                done_reg <= 1'b0;
                if (start[gi]) begin
                    wptr_reg   <= '0;
                    rptr_reg   <= '0;
                    cnt_reg    <= '0;
                    acc_reg    <= cnt_in;
                    wrl_reg    <= cnt_in;
                    addr_reg   <= obaseaddr[gi*BDBANKA +: BDBANKA];
                    stride_reg <= ostride[gi*BDBANKA +: BDBANKA];
                    busy_reg   <= (cnt_in != '0);
                    done_reg   <= (cnt_in == '0);
                end else begin
                    if (push) begin
                        wptr_reg <= wptr_reg + PW'(1);
                        acc_reg  <= acc_reg - BDBANKA'(1);
                    end
                    if (pop[gi]) begin
                        rptr_reg <= rptr_reg + PW'(1);
                        addr_reg <= addr_reg + stride_reg;
                        wrl_reg  <= wrl_reg - BDBANKA'(1);
                        if (wrl_reg == BDBANKA'(1)) begin
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end
                    end
                    case ({push, pop[gi]})
                        2'b10:   cnt_reg <= cnt_reg + CW'(1);
                        2'b01:   cnt_reg <= cnt_reg - CW'(1);
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end
        end
    end

    logic [SW-1:0] sel_reg;
    logic [SW-1:0] last_reg;
    logic [SW-1:0] base;
    logic [SW-1:0] pick;
    logic [SW-1:0] idx;
    logic          found;

    // Search starts just after the channel served last (or being served now).
    always_comb begin
        base  = (pop != '0) ? sel_reg : last_reg;
        found = 1'b0;
        pick  = base;
        idx   = '0;
        for (int k = 1; k <= NMVU; k++) begin
            idx = base + SW'(k);
            if (!found && nonempty_eff[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrc_en   <= '0;
            wrc_addr <= '0;
            wrc_word <= '0;
            sel_reg  <= '0;
            last_reg <= SW'(NMVU - 1);
        end else begin
            if (pop != '0) begin
                last_reg <= sel_reg;
            end
            if (bus_free) begin
                if (found) begin
                    wrc_en   <= NMVU'(1) << pick;
                    sel_reg  <= pick;
                    wrc_addr <= addr_eff[pick];
                    wrc_word <= head_eff[pick];
                end else begin
                    wrc_en <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mvu_outwr.sv
// Self-checking bench for mvu_outwr: directed scenarios plus randomized traffic
// scored against a per-channel queue model of expected writes.
module tb_mvu_outwr;
    localparam int NMVU   = 8;
    localparam int N      = 64;
    localparam int BA     = 15;
    localparam int FDEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NMVU-1:0]    start = '0;
    logic [NMVU*BA-1:0] obaseaddr = '0;
    logic [NMVU*BA-1:0] ostride = '0;
    logic [NMVU*BA-1:0] ocount = '0;
    logic [NMVU-1:0]    q_valid = '0;
    logic [NMVU*N-1:0]  q_word = '0;
    logic [NMVU-1:0]    wrc_grnt = '0;
    logic [NMVU-1:0]    q_ready;
    logic [NMVU-1:0]    wrc_en;
    logic [BA-1:0]      wrc_addr;
    logic [N-1:0]       wrc_word;
    logic [NMVU-1:0]    busy;
    logic [NMVU-1:0]    done;

    always #5 clk = ~clk;

    mvu_outwr #(.NMVU(NMVU), .N(N), .BDBANKA(BA), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .obaseaddr(obaseaddr),
        .ostride(ostride), .ocount(ocount), .q_valid(q_valid), .q_word(q_word),
        .q_ready(q_ready), .wrc_en(wrc_en), .wrc_grnt(wrc_grnt),
        .wrc_addr(wrc_addr), .wrc_word(wrc_word), .busy(busy), .done(done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: each channel is a job descriptor plus a queue of accepted words.
    bit          m_busy [NMVU];
    bit          m_done_next [NMVU];
    int          m_acc [NMVU];
    int          m_wr [NMVU];
    int          m_k [NMVU];
    logic [BA-1:0] m_base [NMVU];
    logic [BA-1:0] m_stride [NMVU];
    logic [N-1:0]  m_q [NMVU][$];
    int          m_hold_ch = -1;

    int            log_ch [$];
    int            log_cyc [$];
    logic [BA-1:0] log_addr [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NMVU; i++) begin
            m_busy[i] = 0; m_done_next[i] = 0;
            m_acc[i] = 0; m_wr[i] = 0; m_k[i] = 0;
            m_q[i].delete();
        end
        m_hold_ch = -1;
    endtask

    task automatic log_clear();
        log_ch.delete(); log_cyc.delete(); log_addr.delete();
    endtask

    task automatic launch(input int ch, input logic [BA-1:0] base,
                          input logic [BA-1:0] stride, input int cnt);
        obaseaddr[ch*BA +: BA] = base;
        ostride[ch*BA +: BA]   = stride;
        ocount[ch*BA +: BA]    = BA'(cnt);
        start[ch]              = 1'b1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < NMVU; i++) q_word[i*N +: N] = {$urandom, $urandom};
    endtask

    function automatic bit model_active();
        bit a = 0;
        for (int i = 0; i < NMVU; i++) a |= m_busy[i] | m_done_next[i];
        return a;
    endfunction

    // Called at a negedge with inputs settled: checks outputs, then applies the
    // coming edge's events to the model and advances one cycle.
    task automatic step();
        logic [NMVU-1:0] e_busy, e_done, e_rdy;
        logic [BA-1:0]   ea;
        int              cnt;
        int              hold_ch;
        for (int i = 0; i < NMVU; i++) begin
            e_busy[i] = m_busy[i];
            e_done[i] = m_done_next[i];
            e_rdy[i]  = m_busy[i] && (m_q[i].size() < FDEPTH) && (m_acc[i] != 0);
        end
        check_eq("busy", 64'(busy), 64'(e_busy));
        check_eq("done", 64'(done), 64'(e_done));
        check_eq("q_ready", 64'(q_ready), 64'(e_rdy));
        check_eq("wrc_en_onehot0", 64'($onehot0(wrc_en)), 64'(1));
        if (m_hold_ch >= 0) check_eq("wrc_en_hold", 64'(wrc_en), 64'(64'd1 << m_hold_ch));
        for (int i = 0; i < NMVU; i++) begin
            if (wrc_en[i]) begin
                check_eq("req_has_data", 64'(m_q[i].size() != 0), 64'(1));
                if (m_q[i].size() != 0) begin
                    ea = m_base[i] + m_stride[i] * BA'(m_k[i]);
                    check_eq("wrc_addr", 64'(wrc_addr), 64'(ea));
                    check_eq("wrc_word", wrc_word, m_q[i][0]);
                end
            end
        end
        hold_ch = -1;
        for (int i = 0; i < NMVU; i++) begin
            m_done_next[i] = 0;
            if (start[i]) begin
                cnt = int'(ocount[i*BA +: BA]);
                m_busy[i] = (cnt != 0); m_acc[i] = cnt; m_wr[i] = cnt; m_k[i] = 0;
                m_base[i] = obaseaddr[i*BA +: BA];
                m_stride[i] = ostride[i*BA +: BA];
                m_q[i].delete();
                m_done_next[i] = (cnt == 0);
            end else begin
                if (wrc_en[i] && wrc_grnt[i]) begin
                    if (m_q[i].size() != 0) begin
                        $display("write ch=%0d addr=0x%04h word=0x%016h cyc=%0d", i, wrc_addr, wrc_word, cyc);
                        log_ch.push_back(i); log_addr.push_back(wrc_addr); log_cyc.push_back(cyc);
                        void'(m_q[i].pop_front());
                        m_k[i]++; m_wr[i]--;
                        if (m_wr[i] == 0) begin m_busy[i] = 0; m_done_next[i] = 1; end
                    end
                end else if (wrc_en[i]) begin
                    hold_ch = i;
                end
                if (q_valid[i] && q_ready[i]) begin
                    m_q[i].push_back(q_word[i*N +: N]);
                    m_acc[i]--;
                end
            end
        end
        m_hold_ch = hold_ch;
        @(posedge clk);
        @(negedge clk);
        start = '0;
        cyc++;
    endtask

    task automatic wait_idle(input int bound);
        logic [NMVU-1:0] mb;
        for (int n = 0; n < bound && model_active(); n++) begin
            rand_words();
            step();
        end
        for (int i = 0; i < NMVU; i++) mb[i] = m_busy[i];
        check_eq("idle_wait_dut", 64'(busy), 64'(0));
        check_eq("idle_wait_model", 64'(mb), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000");
        $fatal(1);
    end

    initial begin
        int d_cnt, b_cnt;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_wrc_en", 64'(wrc_en), 64'(0));
        check_eq("rst_wrc_addr", 64'(wrc_addr), 64'(0));
        check_eq("rst_wrc_word", wrc_word, 64'(0));
        check_eq("rst_q_ready", 64'(q_ready), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        step();

        // Round-robin from reset: channel 0 first.
        log_clear();
        launch(0, 15'h010, 15'd1, 2); launch(3, 15'h030, 15'd1, 2); launch(5, 15'h050, 15'd1, 2);
        step();
        q_valid = 8'b0010_1001;
        repeat (2) begin rand_words(); step(); end
        q_valid = '0;
        wrc_grnt = '1;
        wait_idle(50);
        check_eq("rr_count", 64'(log_ch.size()), 64'(6));
        for (int i = 0; i < 6 && i < log_ch.size(); i++)
            check_eq($sformatf("rr_order[%0d]", i), 64'(log_ch[i]), 64'((i % 3 == 0) ? 0 : (i % 3 == 1) ? 3 : 5));

        // Single channel, grant tied high, back-to-back writes.
        log_clear();
        launch(0, 15'h100, 15'd2, 3);
        step();
        q_valid[0] = 1'b1;
        wait_idle(40);
        q_valid = '0;
        check_eq("single_count", 64'(log_ch.size()), 64'(3));
        for (int i = 0; i < 3 && i < log_addr.size(); i++)
            check_eq($sformatf("single_addr[%0d]", i), 64'(log_addr[i]), 64'(15'h100 + 2 * i));
        if (log_cyc.size() == 3) begin
            check_eq("b2b_1", 64'(log_cyc[1] - log_cyc[0]), 64'(1));
            check_eq("b2b_2", 64'(log_cyc[2] - log_cyc[1]), 64'(1));
        end
        check_eq("single_busy_low", 64'(busy[0]), 64'(0));

        // Grant withheld on channel 2: FIFO fills and q_ready drops.
        log_clear();
        wrc_grnt = '0;
        launch(2, 15'h200, 15'd1, 6);
        step();
        q_valid[2] = 1'b1;
        repeat (8) begin rand_words(); step(); end
        check_eq("full_q_ready", 64'(q_ready[2]), 64'(0));
        check_eq("full_no_write", 64'(log_ch.size()), 64'(0));
        wrc_grnt[2] = 1'b1;
        step();
        wrc_grnt = '0;
        check_eq("one_pop", 64'(log_ch.size()), 64'(1));
        check_eq("q_ready_back", 64'(q_ready[2]), 64'(1));
        wrc_grnt = '1;
        wait_idle(60);
        q_valid = '0;
        check_eq("hold_count", 64'(log_ch.size()), 64'(6));
        if (log_addr.size() == 6) check_eq("hold_last_addr", 64'(log_addr[5]), 64'(15'h205));

        // Address wrap.
        log_clear();
        launch(6, 15'h7FFE, 15'd3, 2);
        step();
        q_valid[6] = 1'b1;
        wait_idle(40);
        q_valid = '0;
        check_eq("wrap_count", 64'(log_addr.size()), 64'(2));
        if (log_addr.size() == 2) begin
            check_eq("wrap_addr0", 64'(log_addr[0]), 64'(15'h7FFE));
            check_eq("wrap_addr1", 64'(log_addr[1]), 64'(15'h0001));
        end

        // Restart while on the bus.
        log_clear();
        wrc_grnt = '0;
        launch(1, 15'h300, 15'd1, 4);
        step();
        q_valid[1] = 1'b1;
        repeat (2) begin rand_words(); step(); end
        q_valid = '0;
        for (int n = 0; n < 10 && !wrc_en[1]; n++) step();
        check_eq("abort_pre_req", 64'(wrc_en), 64'(8'b0000_0010));
        launch(1, 15'h500, 15'd1, 2);
        wrc_grnt = '1;
        step();
        check_eq("abort_en_drop", 64'(wrc_en), 64'(0));
        check_eq("abort_no_write", 64'(log_ch.size()), 64'(0));
        q_valid[1] = 1'b1;
        wait_idle(40);
        q_valid = '0;
        check_eq("abort_count", 64'(log_addr.size()), 64'(2));
        if (log_addr.size() == 2) begin
            check_eq("abort_addr0", 64'(log_addr[0]), 64'(15'h500));
            check_eq("abort_addr1", 64'(log_addr[1]), 64'(15'h501));
        end

        // Zero-length job.
        launch(7, 15'h0, 15'd1, 0);
        step();
        d_cnt = 0; b_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            if (done[7]) d_cnt++;
            if (busy[7]) b_cnt++;
            step();
        end
        check_eq("zero_done_pulses", 64'(d_cnt), 64'(1));
        check_eq("zero_busy_cycles", 64'(b_cnt), 64'(0));

        // Asynchronous reset mid-job.
        wrc_grnt = '0;
        launch(0, 15'h040, 15'd1, 5);
        step();
        q_valid[0] = 1'b1;
        repeat (3) begin rand_words(); step(); end
        q_valid = '0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_wrc_en", 64'(wrc_en), 64'(0));
        check_eq("arst_wrc_addr", 64'(wrc_addr), 64'(0));
        check_eq("arst_wrc_word", wrc_word, 64'(0));
        check_eq("arst_q_ready", 64'(q_ready), 64'(0));
        check_eq("arst_busy", 64'(busy), 64'(0));
        check_eq("arst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) step();

        // Randomized traffic, including occasional restarts of busy channels.
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < NMVU; ch++) begin
                if (!m_busy[ch] && $urandom_range(0, 15) == 0)
                    launch(ch, BA'($urandom), BA'($urandom_range(0, 40)), int'($urandom_range(0, 9)));
                else if (m_busy[ch] && $urandom_range(0, 299) == 0)
                    launch(ch, BA'($urandom), BA'($urandom_range(0, 40)), int'($urandom_range(1, 9)));
            end
            q_valid  = NMVU'($urandom);
            wrc_grnt = NMVU'($urandom) | NMVU'($urandom);
            rand_words();
            step();
        end
        q_valid  = '1;
        wrc_grnt = '1;
        wait_idle(400);
        q_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
